audio_mixer: RTL and testbench

- Final digital stage upstream of the delta-sigma DAC.
- Holds the latest sample of each of the three voices, sums them at a fixed audio sample rate and applies a 4-bit master volume with a serial shift-add multiplier.
- Saturates the result to 14-bit signed.
- Presents it as a one-cycle-valid sample. audio_o and audio_valid_o connect directly to the DAC's audio_i and audio_valid_i.

---
 rtl/tt6581_pkg.sv | 44 ++++
 rtl/shift_add_mul.sv | 65 ++++++
 rtl/audio_mixer.sv | 136 +++++++++++++
 tb/tb_audio_mixer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt6581_pkg.sv
// Shared definitions for the audio path (mixer and delta-sigma DAC).
// Contents:
//   VOICE_W / AUDIO_W / NUM_VOICES / VOL_W / PROD_W : datapath widths
//   voice_t  : signed voice sample
//   audio_t  : signed mixed audio sample, also consumed by the DAC
//   prod_t   : signed volume-scaled product
//   mix_state_t : mixer sequencing states
//   saturate() : scales a product by 1/8 (floor) and clamps to audio_t
package tt6581_pkg;

  localparam int VOICE_W    = 12;
  localparam int AUDIO_W    = 14;
  localparam int NUM_VOICES = 3;
  localparam int VOL_W      = 4;
  // Largest |sum * volume| is 6144 * 15 = 92160, which needs 18 signed bits.
  localparam int PROD_W     = 18;

  typedef logic signed [VOICE_W-1:0] voice_t;
  typedef logic signed [AUDIO_W-1:0] audio_t;
  typedef logic signed [PROD_W-1:0]  prod_t;

  localparam audio_t AUDIO_MAX = audio_t'(8191);
  localparam audio_t AUDIO_MIN = audio_t'(-8192);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SUM,
    ST_MUL,
    ST_SAT
  } mix_state_t;

  // gain = volume / 8: arithmetic shift floors toward -inf, then clamp.
  function automatic audio_t saturate(input prod_t p);
    prod_t r;
    r = p >>> 3;
    if (r > prod_t'(AUDIO_MAX)) begin
      return AUDIO_MAX;
    end else if (r < prod_t'(AUDIO_MIN)) begin
      return AUDIO_MIN;
    end
    return r[AUDIO_W-1:0];
  endfunction

endpackage

// File: rtl/shift_add_mul.sv
// Serial signed x unsigned multiplier, one multiplier bit per cycle.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   start_i         : load operands and clear the accumulator
//   multiplicand_i  : signed operand (mixed voice sum)
//   multiplier_i    : unsigned 4-bit operand (master volume)
//   done_o          : high during the cycle that accumulates the last bit;
//                     prod_o holds the final product from the next cycle on
//   prod_o          : signed accumulated product
module shift_add_mul
  import tt6581_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  audio_t           multiplicand_i,
  input  logic [VOL_W-1:0] multiplier_i,
  output logic             done_o,
  output prod_t            prod_o
);

  prod_t            acc;
  audio_t           mcand;
  logic [VOL_W-1:0] mplier;
  logic [1:0]       bit_idx;
  logic             busy;
  prod_t            addend;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    addend = '0;
    if (mplier[bit_idx]) begin
      addend = prod_t'(mcand) <<< bit_idx;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      bit_idx <= '0;
      busy    <= 1'b0;
    end else if (start_i) begin
      acc     <= '0;
      mcand   <= multiplicand_i;
      mplier  <= multiplier_i;
      bit_idx <= '0;
      busy    <= 1'b1;
    end else if (busy) begin
      acc     <= acc + addend;
      bit_idx <= bit_idx + 2'd1;
      if (bit_idx == 2'(VOL_W - 1)) begin
        busy <= 1'b0;
      end
    end
  end

  assign done_o = busy && (bit_idx == 2'(VOL_W - 1));
  assign prod_o = acc;

endmodule

// File: rtl/audio_mixer.sv
// Three-voice mixer feeding the delta-sigma DAC. Holds the latest sample of
// each voice, sums them once every SAMPLE_DIV cycles, scales by volume/8 with
// a serial multiplier, saturates to 14 bits and emits a one-cycle pulse.
// Ports:
//   clk_i         : system clock (50 MHz)
//   rst_ni        : asynchronous active-low reset
//   voice_valid_i : voice_i / voice_idx_i carry a new sample this cycle
//   voice_idx_i   : voice number 0..2 (3 is ignored)
//   voice_i       : signed 12-bit voice sample
//   volume_i      : master volume 0..15, gain = volume/8
//   audio_valid_o : one-cycle pulse marking a new audio_o
//   audio_o       : signed 14-bit mixed sample, held between pulses
// Timing: tick (count == SAMPLE_DIV-1) is cycle 0; SUM is cycle 1 and its
// closing edge captures the sum and volume; MUL is cycles 2..5; SAT is
// cycle 6; audio_valid_o is high in cycle 7.
module audio_mixer
  import tt6581_pkg::*;
#(
  parameter int SAMPLE_DIV = 1000
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               voice_valid_i,
  input  logic [1:0]         voice_idx_i,
  input  logic [VOICE_W-1:0] voice_i,
  input  logic [VOL_W-1:0]   volume_i,
  output logic               audio_valid_o,
  output logic [AUDIO_W-1:0] audio_o
);

  if (SAMPLE_DIV < 8 || SAMPLE_DIV > 65535) begin : g_bad_sample_div
    $error("audio_mixer: SAMPLE_DIV=%0d outside 8..65535", SAMPLE_DIV);
  end

  localparam logic [15:0] COUNT_LAST = 16'(SAMPLE_DIV - 1);

  logic [15:0] count;
  logic        tick;
  voice_t      hold [NUM_VOICES];
  audio_t      sum;
  mix_state_t  state, state_next;
  logic        mul_start;
  logic        mul_done;
  prod_t       prod;

  assign tick = (count == COUNT_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 16'd1;
    end
  end

  // NOTE: the hold array is only three registers and must read as zero after
  // reset, so it is reset explicitly; large RAM-style arrays would not be.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        hold[i] <= '0;
      end
    end else if (voice_valid_i) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (voice_idx_i == 2'(i)) begin
          hold[i] <= voice_i;
        end
      end
    end
  end

  // Sign-extended sum of the registered holds; a write on the capture edge
  // therefore lands in the next sample, not this one.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      sum = sum + audio_t'(hold[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    mul_start  = 1'b0;
    case (state)
      ST_IDLE: if (tick) state_next = ST_SUM;
      ST_SUM: begin
        mul_start  = 1'b1;
        state_next = ST_MUL;
      end
      ST_MUL:  if (mul_done) state_next = ST_SAT;
      ST_SAT:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Volume is sampled together with the sum, so later changes wait for the
  // next sample.
  shift_add_mul u_mul (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (mul_start),
    .multiplicand_i (sum),
    .multiplier_i   (volume_i),
    .done_o         (mul_done),
    .prod_o         (prod)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      audio_o       <= '0;
      audio_valid_o <= 1'b0;
    end else begin
      audio_valid_o <= (state == ST_SAT);
      if (state == ST_SAT) begin
        audio_o <= saturate(prod);
      end
    end
  end

  // The computation spans 7 cycles and SAMPLE_DIV >= 8, so a tick can only
  // ever arrive while idle.
  tick_only_when_idle: assert property (
    @(posedge clk_i) disable iff (!rst_ni) tick |-> (state == ST_IDLE)
  );

endmodule

// File: tb/tb_audio_mixer.sv
// Self-checking bench for audio_mixer. A behavioural model tracks the voice
// holds and, on every sample-capture edge, computes the expected output as
// clamp(floor((v0+v1+v2) * volume / 8)) together with the edge on which the
// pulse must appear. Each test task drives stimulus and compares inline.
module tb_audio_mixer;
  import tt6581_pkg::*;

  localparam int DIV = 24;

  logic        clk_i;
  logic        rst_ni;
  logic        voice_valid_i;
  logic [1:0]  voice_idx_i;
  logic [11:0] voice_i;
  logic [3:0]  volume_i;
  logic        audio_valid_o;
  logic [13:0] audio_o;

  int n_cmp;
  int n_bad;

  audio_mixer #(.SAMPLE_DIV(DIV)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .voice_valid_i (voice_valid_i),
    .voice_idx_i   (voice_idx_i),
    .voice_i       (voice_i),
    .volume_i      (volume_i),
    .audio_valid_o (audio_valid_o),
    .audio_o       (audio_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- reference model ----------------
  int edge_n;      // rising edges since reset release (first edge = 1)
  int m_hold [3];
  int exp_val;
  int exp_edge;

  function automatic int mix_ref(input int s, input int v);
    int r;
    r = (s * v) >>> 3;
    if (r > 8191) return 8191;
    if (r < -8192) return -8192;
    return r;
  endfunction

  // First tick is the cycle after edge DIV-1; the sum is captured on the
  // edge closing the following cycle, and the pulse shows 5 edges later.
  function automatic bit is_capture(input int e);
    return (e >= DIV + 1) && (((e - DIV - 1) % DIV) == 0);
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      edge_n   <= 0;
      m_hold   <= '{0, 0, 0};
      exp_val  <= 0;
      exp_edge <= -1;
    end else begin
      edge_n <= edge_n + 1;
      if (is_capture(edge_n + 1)) begin
        exp_val  <= mix_ref(m_hold[0] + m_hold[1] + m_hold[2], int'(volume_i));
        exp_edge <= edge_n + 1 + 5;
      end
      if (voice_valid_i && voice_idx_i != 2'd3) begin
        m_hold[int'(voice_idx_i)] <= int'($signed(voice_i));
      end
    end
  end

  // ---------------- stimulus / observation helpers ----------------
  task automatic write_voice(input logic [1:0] idx, input int val);
    voice_valid_i = 1'b1;
    voice_idx_i   = idx;
    voice_i       = 12'(val);
    @(posedge clk_i); #1;
    voice_valid_i = 1'b0;
  endtask

  task automatic wait_edge(input int target);
    while (edge_n < target) begin
      @(posedge clk_i); #1;
    end
  endtask

  task automatic wait_pulse(output bit seen, output int at_edge, output audio_t got);
    seen    = 1'b0;
    at_edge = -1;
    got     = '0;
    for (int i = 0; i < DIV + 16; i++) begin
      @(posedge clk_i); #1;
      if (audio_valid_o === 1'b1) begin
        seen    = 1'b1;
        at_edge = edge_n;
        got     = audio_o;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bit seen; int e; audio_t got;
    rst_ni = 1'b0; voice_valid_i = 1'b0; voice_idx_i = '0; voice_i = '0; volume_i = 4'd8;
    repeat (3) begin @(posedge clk_i); #1; end
    n_cmp++;
    if (audio_o !== 14'd0) begin n_bad++; $display("FAIL reset_audio: got %0d want 0", audio_o); end
    n_cmp++;
    if (audio_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", audio_valid_o); end
    rst_ni = 1'b1;
    wait_pulse(seen, e, got);
    n_cmp++;
    if (!seen || e != DIV + 6) begin
      n_bad++; $display("FAIL reset_first_pulse: seen=%0b edge %0d want %0d", seen, e, DIV + 6);
    end
    n_cmp++;
    if (got !== 14'sd0) begin n_bad++; $display("FAIL reset_first_value: got %0d want 0", got); end
  endtask

  task automatic test_basic();
    bit seen; int e; int e_prev; audio_t got;
    volume_i = 4'd8;
    write_voice(2'd0, 1000); write_voice(2'd1, 1000); write_voice(2'd2, 1000);
    e_prev = -1;
    for (int s = 0; s < 3; s++) begin
      wait_pulse(seen, e, got);
      n_cmp++;
      if (!seen || got !== audio_t'(exp_val) || e != exp_edge) begin
        n_bad++;
        $display("FAIL basic_model s%0d: seen=%0b value %0d edge %0d want %0d edge %0d",
                 s, seen, got, e, exp_val, exp_edge);
      end
      if (s > 0) begin
        n_cmp++;
        if (got !== 14'sd3000) begin n_bad++; $display("FAIL basic_value s%0d: got %0d want 3000", s, got); end
        n_cmp++;
        if (e - e_prev != DIV) begin n_bad++; $display("FAIL basic_period s%0d: got %0d want %0d", s, e - e_prev, DIV); end
      end
      e_prev = e;
      @(posedge clk_i); #1;
      n_cmp++;
      if (audio_valid_o !== 1'b0) begin n_bad++; $display("FAIL basic_pulse_width s%0d: valid still %b", s, audio_valid_o); end
    end
  endtask

  task automatic test_table();
    // voice0, voice1, voice2, volume, expected output
    int tbl [5][5] = '{
      '{ 1000,  1000,  1000,  8,  3000},
      '{ 2047,  2047,  2047, 15,  8191},
      '{-2048, -2048, -2048, 15, -8192},
      '{   -1,     0,     0,  1,    -1},
      '{    0,     0,     0,  0,     0}
    };
    bit seen; int e; audio_t got; int v [3];
    for (int c = 0; c < 5; c++) begin
      for (int k = 0; k < 3; k++) begin
        v[k] = (tbl[c][3] == 0) ? int'($urandom_range(0, 4095)) - 2048 : tbl[c][k];
      end
      volume_i = 4'(tbl[c][3]);
      write_voice(2'd0, v[0]); write_voice(2'd1, v[1]); write_voice(2'd2, v[2]);
      wait_pulse(seen, e, got);
      n_cmp++;
      if (!seen || got !== audio_t'(tbl[c][4])) begin
        n_bad++; $display("FAIL table_case%0d: seen=%0b got %0d want %0d", c, seen, got, tbl[c][4]);
      end
      n_cmp++;
      if (got !== audio_t'(exp_val)) begin
        n_bad++; $display("FAIL table_model%0d: got %0d want %0d", c, got, exp_val);
      end
    end
  endtask

  task automatic test_capture_race();
    bit seen; int p; int e; audio_t got;
    volume_i = 4'd8;
    write_voice(2'd0, 100); write_voice(2'd1, 0); write_voice(2'd2, 0);
    wait_pulse(seen, p, got);
    n_cmp++;
    if (!seen || got !== 14'sd100) begin n_bad++; $display("FAIL race_setup: seen=%0b got %0d want 100", seen, got); end
    wait_edge(p - 5 + DIV - 1);
    voice_valid_i = 1'b1; voice_idx_i = 2'd1; voice_i = 12'd400;
    @(posedge clk_i); #1;
    voice_valid_i = 1'b0;
    wait_pulse(seen, e, got);
    n_cmp++;
    if (!seen || got !== 14'sd100 || got !== audio_t'(exp_val)) begin
      n_bad++; $display("FAIL race_excluded: seen=%0b got %0d want 100 (model %0d)", seen, got, exp_val);
    end
    wait_pulse(seen, e, got);
    n_cmp++;
    if (!seen || got !== 14'sd500) begin n_bad++; $display("FAIL race_included: seen=%0b got %0d want 500", seen, got); end
    write_voice(2'd3, 1234);
    wait_pulse(seen, e, got);
    n_cmp++;
    if (!seen || got !== 14'sd500 || got !== audio_t'(exp_val)) begin
      n_bad++; $display("FAIL idx3_ignored: seen=%0b got %0d want 500 (model %0d)", seen, got, exp_val);
    end
  endtask

  task automatic test_volume_change();
    bit seen; int p; int e; audio_t got;
    volume_i = 4'd8;
    write_voice(2'd1, 0);
    wait_pulse(seen, p, got);
    n_cmp++;
    if (!seen || got !== 14'sd100) begin n_bad++; $display("FAIL vol_setup: seen=%0b got %0d want 100", seen, got); end
    wait_edge(p - 5 + DIV + 1);
    volume_i = 4'd15;
    wait_pulse(seen, e, got);
    n_cmp++;
    if (!seen || got !== 14'sd100 || got !== audio_t'(exp_val)) begin
      n_bad++; $display("FAIL vol_mid_mul: seen=%0b got %0d want 100 (model %0d)", seen, got, exp_val);
    end
    wait_pulse(seen, e, got);
    n_cmp++;
    if (!seen || got !== 14'sd187) begin n_bad++; $display("FAIL vol_next: seen=%0b got %0d want 187", seen, got); end
  endtask

  task automatic test_random();
    bit seen; int e; audio_t got; int nw; int gap;
    for (int s = 0; s < 8; s++) begin
      volume_i = 4'($urandom_range(0, 15));
      nw = int'($urandom_range(1, 4));
      for (int w = 0; w < nw; w++) begin
        gap = int'($urandom_range(0, 2));
        repeat (gap) begin @(posedge clk_i); #1; end
        write_voice(2'($urandom_range(0, 3)), int'($urandom_range(0, 4095)) - 2048);
      end
      wait_pulse(seen, e, got);
      n_cmp++;
      if (!seen || got !== audio_t'(exp_val) || e != exp_edge) begin
        n_bad++;
        $display("FAIL random s%0d: seen=%0b value %0d edge %0d want %0d edge %0d",
                 s, seen, got, e, exp_val, exp_edge);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen; int p; int e; audio_t got;
    volume_i = 4'd15;
    write_voice(2'd0, 100); write_voice(2'd1, 0); write_voice(2'd2, 0);
    wait_pulse(seen, p, got);
    n_cmp++;
    if (!seen || got !== 14'sd187) begin n_bad++; $display("FAIL rstmid_setup: seen=%0b got %0d want 187", seen, got); end
    wait_edge(p - 5 + DIV + 2);
    #2 rst_ni = 1'b0;
    #1;
    n_cmp++;
    if (audio_o !== 14'd0) begin n_bad++; $display("FAIL rstmid_audio: got %0d want 0", audio_o); end
    n_cmp++;
    if (audio_valid_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b want 0", audio_valid_o); end
    #2 rst_ni = 1'b1;
    wait_pulse(seen, e, got);
    n_cmp++;
    if (!seen || e != DIV + 6) begin
      n_bad++; $display("FAIL rstmid_first_pulse: seen=%0b edge %0d want %0d", seen, e, DIV + 6);
    end
    n_cmp++;
    if (got !== 14'sd0) begin n_bad++; $display("FAIL rstmid_holds: got %0d want 0", got); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic();
    test_table();
    test_capture_race();
    test_volume_change();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
